// File: rtl/lcd_scan_out.sv
// LCD scan-out: captures a 64-pixel (8x8) image from the LCD controller and
// streams it to the panel with a valid/ready handshake, one frame per done edge.
module lcd_scan_out (
  input  logic       clk,
  input  logic       reset,
  input  logic       IRAM_valid,
  input  logic [5:0] IRAM_A,
  input  logic [7:0] IRAM_D,
  input  logic       done,
  input  logic       pix_ready,
  output logic       pix_valid,
  output logic [7:0] pix_data,
  output logic [2:0] pix_x,
  output logic [2:0] pix_y,
  output logic       line_start,
  output logic       frame_end,
  output logic       drop_err,
  output logic [7:0] frame_cnt
);

  localparam int unsigned AW    = 6;
  localparam int unsigned DW    = 8;
  localparam int unsigned DEPTH = 64;
  localparam int unsigned CW    = 8;
  localparam int unsigned XW    = 3;

  typedef enum logic [1:0] {
    S_CAPTURE = 2'd0,
    S_SEND    = 2'd1,
    S_GAP     = 2'd2
  } state_e;

  state_e          state_q, state_d;
  logic [AW-1:0]   index_q, index_d;
  logic            done_q;
  logic            pix_valid_q, pix_valid_d;
  logic [DW-1:0]   pix_data_q, pix_data_d;
  logic            line_start_q, line_start_d;
  logic            frame_end_q, frame_end_d;
  logic            drop_err_q, drop_err_d;
  logic [CW-1:0]   frame_cnt_q, frame_cnt_d;

  logic [DW-1:0]   mem_q [DEPTH];
  logic            wr_en;
  logic            done_rise;
  logic [AW-1:0]   index_nxt;

  assign done_rise = done & ~done_q;
  assign index_nxt = index_q + AW'(1);

  // Frame buffer: written only while capturing, contents survive reset
  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem_q[IRAM_A] <= IRAM_D;
    end
  end

  // State and output registers
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q      <= S_CAPTURE;
      index_q      <= '0;
      done_q       <= 1'b0;
      pix_valid_q  <= 1'b0;
      pix_data_q   <= '0;
      line_start_q <= 1'b0;
      frame_end_q  <= 1'b0;
      drop_err_q   <= 1'b0;
      frame_cnt_q  <= '0;
    end else begin
      state_q      <= state_d;
      index_q      <= index_d;
      done_q       <= done;
      pix_valid_q  <= pix_valid_d;
      pix_data_q   <= pix_data_d;
      line_start_q <= line_start_d;
      frame_end_q  <= frame_end_d;
      drop_err_q   <= drop_err_d;
      frame_cnt_q  <= frame_cnt_d;
    end
  end

  // Next-state and next-output logic
  always_comb begin
    state_d      = state_q;
    index_d      = index_q;
    pix_valid_d  = pix_valid_q;
    pix_data_d   = pix_data_q;
    line_start_d = line_start_q;
    frame_end_d  = frame_end_q;
    frame_cnt_d  = frame_cnt_q;
    wr_en        = 1'b0;
    // Any write outside capture is lost and flagged until reset
    drop_err_d   = drop_err_q | (IRAM_valid & (state_q != S_CAPTURE));

    case (state_q)
      S_CAPTURE: begin
        wr_en = IRAM_valid;
        if (done_rise) begin
          state_d      = S_SEND;
          index_d      = '0;
          pix_valid_d  = 1'b1;
          // Same-edge write to pixel 0 must reach the first presented pixel
          pix_data_d   = (IRAM_valid && (IRAM_A == AW'(0))) ? IRAM_D : mem_q[0];
          line_start_d = 1'b1;
          frame_end_d  = 1'b0;
        end
      end
      S_SEND: begin
        if (pix_ready) begin
          if (index_q == AW'(DEPTH - 1)) begin
            state_d      = S_GAP;
            index_d      = '0;
            pix_valid_d  = 1'b0;
            line_start_d = 1'b0;
            frame_end_d  = 1'b0;
            frame_cnt_d  = frame_cnt_q + CW'(1);
          end else begin
            index_d      = index_nxt;
            pix_data_d   = mem_q[index_nxt];
            line_start_d = (index_nxt[XW-1:0] == XW'(0));
            frame_end_d  = (index_nxt == AW'(DEPTH - 1));
          end
        end
      end
      S_GAP: begin
        state_d = S_CAPTURE;
      end
      default: begin
        state_d = S_CAPTURE;
      end
    endcase
  end

  assign pix_valid  = pix_valid_q;
  assign pix_data   = pix_data_q;
  assign pix_x      = index_q[XW-1:0];
  assign pix_y      = index_q[AW-1:XW];
  assign line_start = line_start_q;
  assign frame_end  = frame_end_q;
  assign drop_err   = drop_err_q;
  assign frame_cnt  = frame_cnt_q;

endmodule
